// File: rtl/wb_stage_if.sv
// Memory-stage to writeback-stage bus: the instruction handshake, the commit stall,
// the register-file write port, the forwarding copy and the retire report.
interface wb_stage_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned REG_W = 5
);

  // Upstream handshake and instruction payload
  logic             in_valid;
  logic             in_ready;
  logic [REG_W-1:0] in_rd;
  logic             in_rd_we;
  logic [2:0]       in_mem_op;
  logic [XLEN-1:0]  in_addr;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_mem_rdata;
  logic [XLEN-1:0]  in_pc;

  // Commit port back-pressure
  logic             commit_stall;

  // Register file write port
  logic             write_en;
  logic [REG_W-1:0] reg_write_addr;
  logic [XLEN-1:0]  reg_write_data;

  // Forwarding copy of the pending write
  logic             fwd_valid;
  logic [REG_W-1:0] fwd_addr;
  logic [XLEN-1:0]  fwd_data;

  // Retire report
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic [63:0]      retired_count;

  // Producer side: memory stage, commit logic and register file
  modport master (
    output in_valid, in_rd, in_rd_we, in_mem_op, in_addr,
           in_alu_result, in_mem_rdata, in_pc, commit_stall,
    input  in_ready, write_en, reg_write_addr, reg_write_data,
           fwd_valid, fwd_addr, fwd_data,
           retire_valid, retire_pc, retired_count
  );

  // Writeback stage side
  modport slave (
    input  in_valid, in_rd, in_rd_we, in_mem_op, in_addr,
           in_alu_result, in_mem_rdata, in_pc, commit_stall,
    output in_ready, write_en, reg_write_addr, reg_write_data,
           fwd_valid, fwd_addr, fwd_data,
           retire_valid, retire_pc, retired_count
  );

endinterface

// File: rtl/wb_stage.sv
// Writeback stage: one pipeline register holding a completed instruction,
// load-data extraction/extension, register-file write port with x0 suppression,
// forwarding copy of the pending write and a 64-bit retired-instruction counter.
module wb_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned REG_W = 5
) (
  input logic    clk,
  input logic    rst,
  wb_stage_if.slave bus
);

  localparam int unsigned CNT_W = 64;
  localparam int unsigned OFF_W = 3;

  localparam logic [2:0] OP_ALU = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_LBU = 3'b101;
  localparam logic [2:0] OP_LHU = 3'b110;
  localparam logic [2:0] OP_LWU = 3'b111;

  // WB pipeline register
  logic             valid_q;
  logic [REG_W-1:0] rd_q;
  logic             rd_we_q;
  logic [2:0]       mem_op_q;
  logic [OFF_W-1:0] addr_q;
  logic [XLEN-1:0]  alu_result_q;
  logic [XLEN-1:0]  mem_rdata_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] retired_count_q;

  logic             capture_c;
  logic             retire_c;
  logic             rd_live_c;
  logic [XLEN-1:0]  lane_c;
  logic [XLEN-1:0]  result_c;

  // Only the byte offset within the aligned 8-byte word matters here
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.in_addr[XLEN-1:OFF_W];

  // Handshake and retire qualifiers
  always_comb begin
    bus.in_ready = 1'b1;
    capture_c    = 1'b0;
    retire_c     = 1'b0;
    rd_live_c    = 1'b0;
    bus.in_ready = !valid_q || !bus.commit_stall;
    capture_c    = bus.in_valid && bus.in_ready;
    retire_c     = valid_q && !bus.commit_stall;
    rd_live_c    = rd_we_q && (rd_q != '0);
  end

  // Valid flag: set on capture, cleared when the entry leaves without a replacement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (capture_c) begin
      valid_q <= 1'b1;
    end else if (retire_c) begin
      valid_q <= 1'b0;
    end
  end

  // Payload fields latch on capture and hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      mem_op_q     <= OP_ALU;
      addr_q       <= '0;
      alu_result_q <= '0;
      mem_rdata_q  <= '0;
      pc_q         <= '0;
    end else if (capture_c) begin
      rd_q         <= bus.in_rd;
      rd_we_q      <= bus.in_rd_we;
      mem_op_q     <= bus.in_mem_op;
      addr_q       <= bus.in_addr[OFF_W-1:0];
      alu_result_q <= bus.in_alu_result;
      mem_rdata_q  <= bus.in_mem_rdata;
      pc_q         <= bus.in_pc;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^64
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count_q <= '0;
    end else if (retire_c) begin
      retired_count_q <= retired_count_q + CNT_W'(1);
    end
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    lane_c   = '0;
    result_c = '0;
    lane_c   = mem_rdata_q >> {addr_q, 3'b000};
    case (mem_op_q)
      OP_ALU:  result_c = alu_result_q;
      OP_LB:   result_c = {{(XLEN-8){lane_c[7]}},   lane_c[7:0]};
      OP_LH:   result_c = {{(XLEN-16){lane_c[15]}}, lane_c[15:0]};
      OP_LW:   result_c = {{(XLEN-32){lane_c[31]}}, lane_c[31:0]};
      OP_LD:   result_c = lane_c;
      OP_LBU:  result_c = XLEN'(lane_c[7:0]);
      OP_LHU:  result_c = XLEN'(lane_c[15:0]);
      OP_LWU:  result_c = XLEN'(lane_c[31:0]);
      default: result_c = alu_result_q;
    endcase
  end

  // Register file port, forwarding copy and retire report
  always_comb begin
    bus.write_en       = 1'b0;
    bus.reg_write_addr = '0;
    bus.reg_write_data = '0;
    bus.fwd_valid      = 1'b0;
    bus.fwd_addr       = '0;
    bus.fwd_data       = '0;
    bus.retire_valid   = 1'b0;
    bus.retire_pc      = '0;
    bus.retired_count  = retired_count_q;

    bus.write_en     = retire_c && rd_live_c;
    bus.retire_valid = retire_c;
    if (valid_q) begin
      bus.reg_write_addr = rd_q;
      bus.reg_write_data = result_c;
    end
    if (retire_c) begin
      bus.retire_pc = pc_q;
    end
    // Forwarding stays live while the entry is stalled
    bus.fwd_valid = valid_q && rd_live_c;
    bus.fwd_addr  = rd_q;
    bus.fwd_data  = result_c;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: reset, ALU writeback, load extension,
// x0 suppression, commit stall, back-to-back stream and asynchronous reset.
module tb_wb_stage;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned REG_W = 5;

  localparam logic [2:0] OP_ALU = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_LBU = 3'b101;
  localparam logic [2:0] OP_LHU = 3'b110;
  localparam logic [2:0] OP_LWU = 3'b111;

  localparam logic [63:0] RDATA = 64'h80FF_7F01_8000_00F0;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_cnt;

  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(XLEN), .REG_W(REG_W)) bus ();

  wb_stage #(.XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] rd, input logic we, input logic [2:0] op,
                         input logic [63:0] addr, input logic [63:0] alu,
                         input logic [63:0] rdata, input logic [63:0] pc);
    bus.in_valid      = 1'b1;
    bus.in_rd         = rd;
    bus.in_rd_we      = we;
    bus.in_mem_op     = op;
    bus.in_addr       = addr;
    bus.in_alu_result = alu;
    bus.in_mem_rdata  = rdata;
    bus.in_pc         = pc;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic [4:0] rd, input logic [63:0] data);
    chk({tag, ".we"},   64'(bus.write_en), 64'd1);
    chk({tag, ".addr"}, 64'(bus.reg_write_addr), 64'(rd));
    chk({tag, ".data"}, bus.reg_write_data, data);
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, ".ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".we"},    64'(bus.write_en), 64'd0);
    chk({tag, ".fwd"},   64'(bus.fwd_valid), 64'd0);
    chk({tag, ".ret"},   64'(bus.retire_valid), 64'd0);
    chk({tag, ".wdata"}, bus.reg_write_data, 64'd0);
  endtask

  // One load through the stage: write next cycle, count after retire
  task automatic load_case(input string tag, input logic [2:0] op,
                           input logic [63:0] addr, input logic [63:0] exp);
    present(5'd7, 1'b1, op, addr, 64'hDEAD_BEEF, RDATA, 64'h2000);
    step();
    idle_in();
    chk_write(tag, 5'd7, exp);
    chk({tag, ".fwd_data"}, bus.fwd_data, exp);
    step();
    exp_cnt++;
    chk({tag, ".count"}, bus.retired_count, exp_cnt);
  endtask

  initial begin
    rst = 1'b1;
    bus.commit_stall = 1'b0;
    present(5'd0, 1'b0, OP_ALU, 64'd0, 64'd0, 64'd0, 64'd0);
    idle_in();
    exp_cnt = 64'd0;
    step();
    step();
    chk_idle_out("in_reset");
    chk("in_reset.count", bus.retired_count, 64'd0);
    rst = 1'b0;
    step();
    chk_idle_out("idle");
    chk("idle.count", bus.retired_count, 64'd0);

    // ALU result writeback
    present(5'd5, 1'b1, OP_ALU, 64'd0, 64'h1234, 64'd0, 64'h1000);
    step();
    idle_in();
    chk_write("alu", 5'd5, 64'h1234);
    chk("alu.fwd_valid", 64'(bus.fwd_valid), 64'd1);
    chk("alu.fwd_addr", 64'(bus.fwd_addr), 64'd5);
    chk("alu.retire", 64'(bus.retire_valid), 64'd1);
    chk("alu.retire_pc", bus.retire_pc, 64'h1000);
    step();
    exp_cnt++;
    chk("alu.count", bus.retired_count, exp_cnt);
    chk("alu.we_after", 64'(bus.write_en), 64'd0);

    // Load extraction and extension
    load_case("lb",  OP_LB,  64'h1003, 64'hFFFF_FFFF_FFFF_FF80);
    load_case("lbu", OP_LBU, 64'h1003, 64'h0000_0000_0000_0080);
    load_case("lw",  OP_LW,  64'h1004, 64'hFFFF_FFFF_80FF_7F01);
    load_case("lwu", OP_LWU, 64'h1004, 64'h0000_0000_80FF_7F01);
    load_case("lh",  OP_LH,  64'h1006, 64'hFFFF_FFFF_FFFF_80FF);
    load_case("lhu", OP_LHU, 64'h1006, 64'h0000_0000_0000_80FF);
    load_case("ld",  OP_LD,  64'h1000, 64'h80FF_7F01_8000_00F0);

    // Write to x0: retires and counts, no write, no forward
    present(5'd0, 1'b1, OP_ALU, 64'd0, 64'hBAD, 64'd0, 64'h3000);
    step();
    idle_in();
    chk("x0.we", 64'(bus.write_en), 64'd0);
    chk("x0.fwd", 64'(bus.fwd_valid), 64'd0);
    chk("x0.retire", 64'(bus.retire_valid), 64'd1);
    step();
    exp_cnt++;
    chk("x0.count", bus.retired_count, exp_cnt);

    // rd_we=0: retires without writing
    present(5'd3, 1'b0, OP_ALU, 64'd0, 64'h55, 64'd0, 64'h3004);
    step();
    idle_in();
    chk("nowe.we", 64'(bus.write_en), 64'd0);
    chk("nowe.fwd", 64'(bus.fwd_valid), 64'd0);
    chk("nowe.retire", 64'(bus.retire_valid), 64'd1);
    step();
    exp_cnt++;
    chk("nowe.count", bus.retired_count, exp_cnt);

    // Commit stall for three cycles with an entry held and the next one waiting
    bus.commit_stall = 1'b1;
    present(5'd9, 1'b1, OP_ALU, 64'd0, 64'hA, 64'd0, 64'h4000);
    step();
    present(5'd10, 1'b1, OP_ALU, 64'd0, 64'hB, 64'd0, 64'h4004);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall.ready", 64'(bus.in_ready), 64'd0);
      chk("stall.we", 64'(bus.write_en), 64'd0);
      chk("stall.fwd", 64'(bus.fwd_valid), 64'd1);
      chk("stall.fwd_addr", 64'(bus.fwd_addr), 64'd9);
      chk("stall.fwd_data", bus.fwd_data, 64'hA);
      chk("stall.count", bus.retired_count, exp_cnt);
      if (i < 2) step();
    end
    bus.commit_stall = 1'b0;
    #1;
    chk_write("release.a", 5'd9, 64'hA);
    chk("release.ready", 64'(bus.in_ready), 64'd1);
    step();
    idle_in();
    exp_cnt++;
    chk_write("release.b", 5'd10, 64'hB);
    chk("release.retire_pc", bus.retire_pc, 64'h4004);
    chk("release.count", bus.retired_count, exp_cnt);
    step();
    exp_cnt++;
    chk("release.count2", bus.retired_count, exp_cnt);
    chk("release.we_after", 64'(bus.write_en), 64'd0);

    // Reset pulse clears the counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 64'd0;
    step();
    chk("rst2.count", bus.retired_count, exp_cnt);

    // Back-to-back stream of four, one write per cycle
    for (int i = 0; i < 4; i++) begin
      present(5'(i + 1), 1'b1, OP_ALU, 64'd0, 64'h100 + 64'(i), 64'd0, 64'h5000 + 64'(4 * i));
      step();
      chk_write("stream", 5'(i + 1), 64'h100 + 64'(i));
      chk("stream.count", bus.retired_count, 64'(i));
    end
    idle_in();
    step();
    chk("stream.count_final", bus.retired_count, 64'd4);
    chk("stream.we_after", 64'(bus.write_en), 64'd0);

    // Reset in the middle of a stream discards the held entry at once
    present(5'd20, 1'b1, OP_ALU, 64'd0, 64'h77, 64'd0, 64'h6000);
    step();
    present(5'd21, 1'b1, OP_ALU, 64'd0, 64'h78, 64'd0, 64'h6004);
    step();
    chk_write("midrst.pre", 5'd21, 64'h78);
    rst = 1'b1;
    idle_in();
    #1;
    chk_idle_out("midrst");
    chk("midrst.count", bus.retired_count, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("midrst.we_after", 64'(bus.write_en), 64'd0);
    chk("midrst.count_after", bus.retired_count, 64'd0);

    // Reset while stalled: held entry never writes
    bus.commit_stall = 1'b1;
    present(5'd12, 1'b1, OP_ALU, 64'd0, 64'h99, 64'd0, 64'h7000);
    step();
    idle_in();
    chk("stallrst.fwd", 64'(bus.fwd_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("stallrst.fwd_rst", 64'(bus.fwd_valid), 64'd0);
    step();
    rst = 1'b0;
    bus.commit_stall = 1'b0;
    #1;
    chk("stallrst.we", 64'(bus.write_en), 64'd0);
    chk("stallrst.retire", 64'(bus.retire_valid), 64'd0);
    step();
    chk("stallrst.count", bus.retired_count, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
